// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory-access pipeline stage: opcode/funct
// widths, the load/store opcodes it reacts to, and its FSM state codes.
package memory_stage_pkg;

    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;

    localparam logic [OPCODE_WIDTH-1:0] LOAD  = 6'b100011;
    localparam logic [OPCODE_WIDTH-1:0] STORE = 6'b101011;

    localparam logic [0:0] MS_IDLE = 1'b0;
    localparam logic [0:0] MS_WAIT = 1'b1;

    // True for the two opcodes that need the data-memory port.
    function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] op);
        return (op == LOAD) || (op == STORE);
    endfunction

endpackage

// File: rtl/memory_stage.sv
// Memory-access pipeline stage: passes non-memory instructions straight to
// writeback, runs aligned word loads/stores over a req/ack port with a
// bounded wait, and stalls execute while a transfer is outstanding.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int PC_WIDTH   = 32,
    parameter int AWIDTH     = 32,
    parameter int REG_AWIDTH = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic                    ms_clk,
    input  logic                    ms_rst,
    input  logic                    ms_i_ce,
    input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
    input  logic [FUNCT_WIDTH-1:0]  ms_i_funct,
    input  logic [DWIDTH-1:0]       ms_i_alu_value,
    input  logic [DWIDTH-1:0]       ms_i_store_data,
    input  logic [REG_AWIDTH-1:0]   ms_i_rd_addr,
    input  logic                    ms_i_regwrite,
    input  logic                    ms_i_change_pc,
    input  logic [PC_WIDTH-1:0]     ms_i_alu_pc,
    output logic                    ms_o_stall,
    output logic                    ms_o_mem_req,
    output logic                    ms_o_mem_we,
    output logic [AWIDTH-1:0]       ms_o_mem_addr,
    output logic [DWIDTH-1:0]       ms_o_mem_wdata,
    input  logic                    ms_i_mem_ack,
    input  logic [DWIDTH-1:0]       ms_i_mem_rdata,
    output logic                    ms_o_ce,
    output logic [OPCODE_WIDTH-1:0] ms_o_opcode,
    output logic [FUNCT_WIDTH-1:0]  ms_o_funct,
    output logic [REG_AWIDTH-1:0]   ms_o_rd_addr,
    output logic                    ms_o_regwrite,
    output logic                    ms_o_change_pc,
    output logic [PC_WIDTH-1:0]     ms_o_alu_pc,
    output logic [DWIDTH-1:0]       ms_o_wb_data,
    output logic                    ms_o_misaligned,
    output logic                    ms_o_bus_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [0:0]              state;
    logic [TW-1:0]           timer;
    logic [OPCODE_WIDTH-1:0] cap_opcode;
    logic [FUNCT_WIDTH-1:0]  cap_funct;
    logic [REG_AWIDTH-1:0]   cap_rd_addr;
    logic                    cap_regwrite;
    logic                    cap_change_pc;
    logic [PC_WIDTH-1:0]     cap_alu_pc;
    logic [DWIDTH-1:0]       cap_alu_value;
    logic [DWIDTH-1:0]       cap_wdata;
    logic                    cap_we;

    logic mem_op;
    logic aligned;
    logic timed_out;

    assign mem_op    = is_mem_op(ms_i_opcode);
    assign aligned   = (ms_i_alu_value[1:0] == 2'b00);
    assign timed_out = (timer == TW'(TIMEOUT - 1));

    // Bus outputs come from the captured request and are only visible while waiting.
    assign ms_o_mem_req   = (state == MS_WAIT);
    assign ms_o_mem_we    = (state == MS_WAIT) && cap_we;
    assign ms_o_mem_addr  = (state == MS_WAIT) ? cap_alu_value[AWIDTH-1:0] : '0;
    assign ms_o_mem_wdata = (state == MS_WAIT) ? cap_wdata : '0;

    // Hold upstream while an aligned access is being launched or is still pending.
    always_comb begin
        ms_o_stall = 1'b0;
        case (state)
            MS_IDLE: ms_o_stall = ms_i_ce && mem_op && aligned;
            MS_WAIT: ms_o_stall = !ms_i_mem_ack && !timed_out;
            default: ms_o_stall = 1'b0;
        endcase
    end

    // FSM, capture registers and the writeback-facing result registers.
    always_ff @(posedge ms_clk) begin
        if (ms_rst) begin
            state           <= MS_IDLE;
            timer           <= '0;
            cap_opcode      <= '0;
            cap_funct       <= '0;
            cap_rd_addr     <= '0;
            cap_regwrite    <= 1'b0;
            cap_change_pc   <= 1'b0;
            cap_alu_pc      <= '0;
            cap_alu_value   <= '0;
            cap_wdata       <= '0;
            cap_we          <= 1'b0;
            ms_o_ce         <= 1'b0;
            ms_o_opcode     <= '0;
            ms_o_funct      <= '0;
            ms_o_rd_addr    <= '0;
            ms_o_regwrite   <= 1'b0;
            ms_o_change_pc  <= 1'b0;
            ms_o_alu_pc     <= '0;
            ms_o_wb_data    <= '0;
            ms_o_misaligned <= 1'b0;
            ms_o_bus_err    <= 1'b0;
        end else begin
            ms_o_ce         <= 1'b0;
            ms_o_opcode     <= '0;
            ms_o_funct      <= '0;
            ms_o_rd_addr    <= '0;
            ms_o_regwrite   <= 1'b0;
            ms_o_change_pc  <= 1'b0;
            ms_o_alu_pc     <= '0;
            ms_o_wb_data    <= '0;
            ms_o_misaligned <= 1'b0;
            ms_o_bus_err    <= 1'b0;
            case (state)
                MS_IDLE: begin
                    if (ms_i_ce) begin
                        if (mem_op && aligned) begin
                            cap_opcode    <= ms_i_opcode;
                            cap_funct     <= ms_i_funct;
                            cap_rd_addr   <= ms_i_rd_addr;
                            cap_regwrite  <= ms_i_regwrite;
                            cap_change_pc <= ms_i_change_pc;
                            cap_alu_pc    <= ms_i_alu_pc;
                            cap_alu_value <= ms_i_alu_value;
                            cap_wdata     <= ms_i_store_data;
                            cap_we        <= (ms_i_opcode == STORE);
                            timer         <= '0;
                            state         <= MS_WAIT;
                        end else begin
                            ms_o_ce         <= 1'b1;
                            ms_o_opcode     <= ms_i_opcode;
                            ms_o_funct      <= ms_i_funct;
                            ms_o_rd_addr    <= ms_i_rd_addr;
                            ms_o_regwrite   <= ms_i_regwrite && !mem_op;
                            ms_o_change_pc  <= ms_i_change_pc;
                            ms_o_alu_pc     <= ms_i_alu_pc;
                            ms_o_wb_data    <= ms_i_alu_value;
                            ms_o_misaligned <= mem_op;
                        end
                    end
                end
                MS_WAIT: begin
                    if (ms_i_mem_ack || timed_out) begin
                        ms_o_ce        <= 1'b1;
                        ms_o_opcode    <= cap_opcode;
                        ms_o_funct     <= cap_funct;
                        ms_o_rd_addr   <= cap_rd_addr;
                        ms_o_change_pc <= cap_change_pc;
                        ms_o_alu_pc    <= cap_alu_pc;
                        ms_o_regwrite  <= ms_i_mem_ack && cap_regwrite && !cap_we;
                        ms_o_bus_err   <= !ms_i_mem_ack;
                        ms_o_wb_data   <= (ms_i_mem_ack && !cap_we) ? ms_i_mem_rdata
                                                                    : cap_alu_value;
                        timer          <= '0;
                        state          <= MS_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= MS_IDLE;
            endcase
        end
    end

endmodule
